ex_redirect_ctrl: RTL and testbench
===================================

# ex_redirect_ctrl

Control-transfer sequencer sitting between the execute stage and fetch. It watches each instruction leaving execute and compares the computed next PC against the sequential PC. On a mismatch it kills the wrong-path instructions in IF/ID and ID/EX, then holds a redirect request to fetch until fetch accepts it. It also latches HALT and keeps saturating redirect and penalty counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute holds a real (non-bubble) instruction this cycle
- ex_ctl  in  1  instruction is a jump or branch (jump | branch decode)
- ex_halt  in  1  instruction is HALT
- ex_next_pc  in  16  next PC computed by execute
- ex_seq_pc  in  16  PC+2 of the instruction in execute
- pipe_stall  in  1  global stall; execute is frozen and re-presents the same instruction next cycle
- fetch_ready  in  1  fetch accepts redirect this cycle
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  16  redirect target
- flush_ifid  out  1  invalidate the IF/ID register at the next edge
- flush_idex  out  1  invalidate the ID/EX register at the next edge
- fetch_hold  out  1  fetch must not advance PC
- halted  out  1  processor halted
- redirect_count  out  CNT_W  number of redirects taken, saturating
- penalty_count  out  CNT_W  REDIR cycles with fetch_ready low, saturating

## Operation
- States: RUN, REDIR, HALT. Reset state is RUN.
- fire = ex_valid & ~pipe_stall, evaluated in RUN only.
- take = fire & ex_ctl & ~ex_halt & (ex_next_pc != ex_seq_pc).
  - A jump whose target equals PC+2 is not a redirect.
- RUN:
  - fire & ex_halt → HALT. Halt has priority over take.
  - Otherwise take → REDIR, with redir_pc_q ← ex_next_pc and redirect_count += 1.
  - Otherwise stay in RUN.
- REDIR:
  - redir_valid = 1, flush_ifid = flush_idex = 1, fetch_hold = 0.
  - All ex_* inputs are wrong-path and are ignored, including ex_halt.
  - fetch_ready = 1 → RUN.
  - fetch_ready = 0 → stay in REDIR and increment penalty_count.
  - pipe_stall does not block the handshake.
- HALT:
  - halted = 1, fetch_hold = 1, all other outputs 0.
  - Left only by rst.
- Flush outputs are Mealy-type.
  - In RUN: flush_ifid = flush_idex = take (combinational, same cycle as detection).
  - In REDIR: both are 1.
  - In HALT: both are 0.
- redir_pc drives redir_pc_q. redir_pc_q holds its value in RUN and HALT and is only meaningful while redir_valid = 1.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: state RUN, redir_pc_q 0, both counters 0.
  - With inputs idle, every output is 0 in the cycle after rst.
- Detection in cycle T:
  - Flushes are high in T.
  - redir_valid and redir_pc are valid from T+1.
  - With fetch_ready = 1 at T+1, state is RUN at T+2.
  - Minimum penalty is 2 cycles: the detect cycle plus 1 REDIR cycle.
- Back-to-back: a take detected in the first RUN cycle after REDIR is legal and re-enters REDIR immediately.
- take while pipe_stall = 1: no action. The same instruction is re-evaluated each cycle until the stall drops; it fires exactly once.
- rst mid-REDIR: the pending redirect is discarded; no redir_valid in the cycle after reset.
- rst in HALT → RUN.
- No combinational path exists from fetch_ready to any output except through state.

## Structure
- Package ex_ctrl_pkg holds:
  - the state typedef (RUN, REDIR, HALT)
  - the default CNT_W
- Sub-module sat_counter (parameter W; ports clk, rst, inc, cnt) is instantiated twice, once per statistics counter.
- FSM, compare and output logic live in ex_redirect_ctrl.

## Test plan
- Taken branch: ex_valid = ex_ctl = 1, next_pc = 0x0040, seq_pc = 0x0012, fetch_ready = 1 → flushes high at T; redir_valid = 1 with redir_pc = 0x0040 at T+1; RUN at T+2; redirect_count = 1.
- Not-taken branch: next_pc = seq_pc = 0x0012 → no flush, no redir_valid, counters unchanged.
- Fetch backpressure: taken jump, fetch_ready low for 3 cycles then high → redir_valid held 4 cycles with redir_pc stable; penalty_count = 3; flushes high throughout.
- Stall: taken branch presented with pipe_stall = 1 for 2 cycles, then 0 → exactly one redirect, issued after the stall clears; redirect_count = 1.
- Halt and wrong-path halt:
  - ex_halt during REDIR → ignored.
  - ex_halt in RUN → halted = fetch_hold = 1 forever.
  - rst → all outputs 0, counters 0.
- Saturation: force 2^CNT_W+1 redirects with CNT_W = 4 → redirect_count stops at 0xF.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// rtl/ex_ctrl_pkg.sv - shared types and defaults for the execute redirect controller
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance statistics
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Sticks at all-ones so a long debug run never reports a small wrapped value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ex_redirect_ctrl.sv
// rtl/ex_redirect_ctrl.sv - execute-to-fetch redirect sequencer with halt latch and stats
module ex_redirect_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_ctl,
    input  logic             ex_halt,
    input  logic [15:0]      ex_next_pc,
    input  logic [15:0]      ex_seq_pc,
    input  logic             pipe_stall,
    input  logic             fetch_ready,
    output logic             redir_valid,
    output logic [15:0]      redir_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             fetch_hold,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count,
    output logic [CNT_W-1:0] penalty_count
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] redir_pc_q;
    logic [15:0] redir_pc_d;
    logic        fire;
    logic        take;
    logic        flush;
    logic        redir_inc;
    logic        penalty_inc;

    always_comb begin
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        fire        = 1'b0;
        take        = 1'b0;
        flush       = 1'b0;
        redir_valid = 1'b0;
        fetch_hold  = 1'b0;
        halted      = 1'b0;
        redir_inc   = 1'b0;
        penalty_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                fire  = ex_valid & ~pipe_stall;
                take  = fire & ex_ctl & ~ex_halt & (ex_next_pc != ex_seq_pc);
                // Wrong-path kill happens in the detect cycle itself.
                flush = take;
                if (fire && ex_halt) begin
                    state_d = ST_HALT;
                end else if (take) begin
                    state_d    = ST_REDIR;
                    redir_pc_d = ex_next_pc;
                    redir_inc  = 1'b1;
                end
            end
            ST_REDIR: begin
                // Execute contents are wrong-path here, so ex_* is deliberately unused.
                redir_valid = 1'b1;
                flush       = 1'b1;
                if (fetch_ready) begin
                    state_d = ST_RUN;
                end else begin
                    penalty_inc = 1'b1;
                end
            end
            ST_HALT: begin
                halted     = 1'b1;
                fetch_hold = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            redir_pc_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign redir_pc   = redir_pc_q;
    assign flush_ifid = flush;
    assign flush_idex = flush;

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_inc),
        .cnt (redirect_count)
    );

    sat_counter #(.W(CNT_W)) u_penalty_cnt (
        .clk (clk),
        .rst (rst),
        .inc (penalty_inc),
        .cnt (penalty_count)
    );

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// tb/tb_ex_redirect_ctrl.sv - scoreboard bench for ex_redirect_ctrl against a behavioural model
module tb_ex_redirect_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic          ex_ctl;
    logic          ex_halt;
    logic [15:0]   ex_next_pc;
    logic [15:0]   ex_seq_pc;
    logic          pipe_stall;
    logic          fetch_ready;
    logic          redir_valid;
    logic [15:0]   redir_pc;
    logic          flush_ifid;
    logic          flush_idex;
    logic          fetch_hold;
    logic          halted;
    logic [CW-1:0] redirect_count;
    logic [CW-1:0] penalty_count;

    ex_redirect_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ctl         (ex_ctl),
        .ex_halt        (ex_halt),
        .ex_next_pc     (ex_next_pc),
        .ex_seq_pc      (ex_seq_pc),
        .pipe_stall     (pipe_stall),
        .fetch_ready    (fetch_ready),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .fetch_hold     (fetch_hold),
        .halted         (halted),
        .redirect_count (redirect_count),
        .penalty_count  (penalty_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: one pending redirect slot, a halted flag, two integer counters.
    bit          m_pending;
    bit          m_halted;
    logic [15:0] m_pc;
    int          m_rc;
    int          m_pen;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic c, input logic h,
                       input logic [15:0] np, input logic [15:0] sp,
                       input logic st, input logic fr, input logic r);
        bit fire;
        bit take;
        @(negedge clk);
        ex_valid = v; ex_ctl = c; ex_halt = h; ex_next_pc = np; ex_seq_pc = sp;
        pipe_stall = st; fetch_ready = fr; rst = r;
        #1;
        fire = v && !st && !m_pending && !m_halted;
        take = fire && c && !h && (np != sp);
        chk("redir_valid", redir_valid, m_pending);
        if (m_pending) chk("redir_pc", redir_pc, m_pc);
        chk("flush_ifid", flush_ifid, m_pending || take);
        chk("flush_idex", flush_idex, m_pending || take);
        chk("fetch_hold", fetch_hold, m_halted);
        chk("halted", halted, m_halted);
        chk("redirect_count", redirect_count, m_rc);
        chk("penalty_count", penalty_count, m_pen);
        if (r) begin
            m_pending = 0; m_halted = 0; m_pc = 16'h0; m_rc = 0; m_pen = 0;
            exp_q.delete();
        end else if (m_pending) begin
            if (fr) m_pending = 0;
            else if (m_pen < SAT) m_pen++;
        end else if (fire && h) begin
            m_halted = 1;
        end else if (take) begin
            m_pending = 1;
            m_pc = np;
            if (m_rc < SAT) m_rc++;
            exp_q.push_back(np);
        end
    endtask

    task automatic idle(input logic fr);
        cyc(0, 0, 0, 16'h0, 16'h0, 0, fr, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 1);
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    endtask

    // Monitor: every accepted redirect must match the oldest predicted target.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1 && redir_valid === 1'b1 && fetch_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected at %0t: got redirect 0x%0h expected none", $time, redir_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_redir_pc", redir_pc, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] sp;
        logic [15:0] np;
        rst = 1; ex_valid = 0; ex_ctl = 0; ex_halt = 0; ex_next_pc = 0; ex_seq_pc = 0;
        pipe_stall = 0; fetch_ready = 0;
        m_pending = 0; m_halted = 0; m_pc = 0; m_rc = 0; m_pen = 0;
        @(negedge clk);
        do_reset();
        idle(0);
        idle(1);

        // Taken branch, fetch ready immediately.
        cyc(1, 1, 0, 16'h0040, 16'h0012, 0, 1, 0);
        idle(1);
        idle(1);
        // Not-taken branch.
        cyc(1, 1, 0, 16'h0012, 16'h0012, 0, 1, 0);
        idle(1);
        // Backpressure: three cycles with fetch_ready low.
        cyc(1, 1, 0, 16'h0100, 16'h0050, 0, 0, 0);
        idle(0); idle(0); idle(0);
        idle(1);
        idle(1);
        // Stall holds the same taken branch for two cycles.
        cyc(1, 1, 0, 16'h0200, 16'h0080, 1, 1, 0);
        cyc(1, 1, 0, 16'h0200, 16'h0080, 1, 1, 0);
        cyc(1, 1, 0, 16'h0200, 16'h0080, 0, 1, 0);
        idle(1);
        // Back-to-back redirect right after REDIR.
        cyc(1, 1, 0, 16'h0300, 16'h0090, 0, 0, 0);
        cyc(1, 1, 0, 16'h0300, 16'h0090, 0, 1, 0);
        cyc(1, 1, 0, 16'h0400, 16'h0302, 0, 1, 0);
        idle(1);
        // Wrong-path halt during REDIR is ignored.
        cyc(1, 1, 0, 16'h0500, 16'h00a0, 0, 0, 0);
        cyc(1, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        cyc(1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        idle(1);
        // Real halt, then taken branches are ignored until reset.
        cyc(1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        cyc(1, 1, 0, 16'h0600, 16'h00b0, 0, 1, 0);
        idle(1); idle(0);
        // Reset mid-REDIR discards the redirect.
        do_reset();
        idle(1);
        cyc(1, 1, 0, 16'h0700, 16'h00c0, 0, 0, 0);
        do_reset();
        idle(1);
        idle(1);

        // Saturation of both counters.
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            cyc(1, 1, 0, 16'h1000 + 16'(i * 4), 16'h0010, 0, 0, 0);
            cyc(0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        end
        cyc(1, 1, 0, 16'h2000, 16'h0010, 0, 0, 0);
        for (int i = 0; i < 20; i++) idle(0);
        idle(1);
        idle(1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            sp = 16'($urandom) & 16'hfffe;
            np = ($urandom_range(0, 9) < 3) ? sp : (16'($urandom) & 16'hfffe);
            if ($urandom_range(0, 99) < 2) begin
                cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 1);
            end else begin
                cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 99) < 3), np, sp,
                    1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 6), 0);
            end
        end
        idle(1);
        idle(1);
        chk("sb_queue_drained", exp_q.size(), (m_pending ? 1 : 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
